// File: rtl/flow_unit.sv
`default_nettype none
// ============================================================================
// flow_unit: program-flow unit owning PC, status register and trap return
// address; executes trap/jump/status operations and steers fetch.
// Revision: 1.0
// ============================================================================
module flow_unit #(
  parameter int unsigned        WIDTH    = 20,
  parameter logic [WIDTH-1:0]   RESET_PC = '0,
  parameter logic [WIDTH-1:0]   TRAP_VEC = 20'hFFF00
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flag_valid,
  input  logic             alu_zero,
  input  logic             alu_sign,
  input  logic             alu_carry,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [2:0]       op_code,
  input  logic [WIDTH-1:0] op_target,
  input  logic [2:0]       op_imm,
  input  logic             trap_ack,
  output logic [WIDTH-1:0] pc,
  output logic [2:0]       status,
  output logic [WIDTH-1:0] epc,
  output logic             redirect,
  output logic             trap_active
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_TRAP  = 2'd2
  } state_t;

  localparam logic [2:0] c_OP_TRAP = 3'd0;
  localparam logic [2:0] c_OP_NOP  = 3'd1;
  localparam logic [2:0] c_OP_JMP  = 3'd2;
  localparam logic [2:0] c_OP_JZ   = 3'd3;
  localparam logic [2:0] c_OP_JS   = 3'd4;
  localparam logic [2:0] c_OP_JZS  = 3'd5;
  localparam logic [2:0] c_OP_LDSR = 3'd6;
  localparam logic [2:0] c_OP_XSR  = 3'd7;

  state_t           r_state, w_state_next;
  logic [WIDTH-1:0] r_pc, w_pc_next;
  logic [2:0]       r_status, w_status_next;
  logic [WIDTH-1:0] r_epc, w_epc_next;
  logic             r_redirect, w_redirect_next;
  logic             w_accept;
  logic             w_taken;
  logic [WIDTH-1:0] w_pc_inc;

  assign w_accept = op_valid && (r_state == ST_RUN);
  assign w_pc_inc = r_pc + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_RUN;
      r_pc       <= RESET_PC;
      r_status   <= 3'b000;
      r_epc      <= '0;
      r_redirect <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_pc       <= w_pc_next;
      r_status   <= w_status_next;
      r_epc      <= w_epc_next;
      r_redirect <= w_redirect_next;
    end
  end

  // Jump conditions look only at the registered status; flags are not forwarded.
  always_comb begin
    w_taken = 1'b0;
    case (op_code)
      c_OP_JMP: w_taken = 1'b1;
      c_OP_JZ:  w_taken = r_status[0];
      c_OP_JS:  w_taken = r_status[1];
      c_OP_JZS: w_taken = r_status[0] | r_status[1];
      default:  w_taken = 1'b0;
    endcase
  end

  always_comb begin
    w_state_next    = r_state;
    w_pc_next       = r_pc;
    w_epc_next      = r_epc;
    w_redirect_next = 1'b0;
    w_status_next   = flag_valid ? {alu_carry, alu_sign, alu_zero} : r_status;
    case (r_state)
      ST_RUN: begin
        if (w_accept) begin
          case (op_code)
            c_OP_TRAP: begin
              w_epc_next      = r_pc;
              w_pc_next       = TRAP_VEC;
              w_state_next    = ST_TRAP;
              w_redirect_next = 1'b1;
            end
            c_OP_NOP: w_pc_next = w_pc_inc;
            c_OP_JMP, c_OP_JZ, c_OP_JS, c_OP_JZS: begin
              if (w_taken) begin
                w_pc_next       = op_target;
                w_state_next    = ST_FLUSH;
                w_redirect_next = 1'b1;
              end else begin
                w_pc_next = w_pc_inc;
              end
            end
            // Status operations override any flags captured this cycle.
            c_OP_LDSR: begin
              w_status_next = op_imm;
              w_pc_next     = w_pc_inc;
            end
            c_OP_XSR: begin
              w_status_next = r_status ^ op_imm;
              w_pc_next     = w_pc_inc;
            end
            default: w_pc_next = r_pc;
          endcase
        end
      end
      ST_FLUSH: w_state_next = ST_RUN;
      ST_TRAP: begin
        if (trap_ack) w_state_next = ST_RUN;
      end
      default: w_state_next = ST_RUN;
    endcase
  end

  assign op_ready    = (r_state == ST_RUN);
  assign trap_active = (r_state == ST_TRAP);
  assign redirect    = r_redirect;
  assign pc          = r_pc;
  assign status      = r_status;
  assign epc         = r_epc;

endmodule
`default_nettype wire

// File: tb/tb_flow_unit.sv
`default_nettype none
// ============================================================================
// tb_flow_unit: directed self-checking bench for flow_unit.
// Revision: 1.0
// ============================================================================
module tb_flow_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flag_valid, alu_zero, alu_sign, alu_carry;
  logic        op_valid, op_ready;
  logic [2:0]  op_code, op_imm;
  logic [19:0] op_target;
  logic        trap_ack;
  logic [19:0] pc, epc;
  logic [2:0]  status;
  logic        redirect, trap_active;

  int checks = 0;
  int errors = 0;

  flow_unit #(.WIDTH(20), .RESET_PC(20'h00000), .TRAP_VEC(20'hFFF00)) dut (
    .clk(clk), .rst_n(rst_n), .flag_valid(flag_valid),
    .alu_zero(alu_zero), .alu_sign(alu_sign), .alu_carry(alu_carry),
    .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
    .op_target(op_target), .op_imm(op_imm), .trap_ack(trap_ack),
    .pc(pc), .status(status), .epc(epc), .redirect(redirect),
    .trap_active(trap_active)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    op_valid   = 1'b0;
    flag_valid = 1'b0;
    trap_ack   = 1'b0;
  endtask

  task automatic issue(input logic [2:0] code, input logic [19:0] tgt, input logic [2:0] imm);
    op_valid  = 1'b1;
    op_code   = code;
    op_target = tgt;
    op_imm    = imm;
    tick();
    op_valid  = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_pc"}, pc, 20'h0);
    check({tag, "_status"}, status, 3'b000);
    check({tag, "_epc"}, epc, 20'h0);
    check({tag, "_ready"}, op_ready, 1'b1);
    check({tag, "_redirect"}, redirect, 1'b0);
    check({tag, "_trap_active"}, trap_active, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    op_code = 3'd1; op_target = '0; op_imm = '0;
    alu_zero = 1'b0; alu_sign = 1'b0; alu_carry = 1'b0;
    idle();
    tick(); tick();
    check_reset_vals("reset");
    rst_n = 1'b1;

    // Three sequential NOPs.
    for (int i = 1; i <= 3; i++) begin
      issue(3'd1, 20'h0, 3'b0);
      check($sformatf("nop%0d_pc", i), pc, i);
      check($sformatf("nop%0d_ready", i), op_ready, 1'b1);
      check($sformatf("nop%0d_redirect", i), redirect, 1'b0);
    end

    // Zero flag captured, then taken JZ.
    flag_valid = 1'b1; alu_zero = 1'b1;
    tick();
    flag_valid = 1'b0; alu_zero = 1'b0;
    check("flag_status", status, 3'b001);
    issue(3'd3, 20'h00400, 3'b0);
    check("jz_pc", pc, 20'h00400);
    check("jz_redirect", redirect, 1'b1);
    check("jz_ready_low", op_ready, 1'b0);
    tick();
    check("jz_flush_redirect", redirect, 1'b0);
    check("jz_flush_ready", op_ready, 1'b1);

    // Clear status, then all conditional jumps fall through.
    issue(3'd6, 20'h0, 3'b000);
    check("ldsr0_status", status, 3'b000);
    check("ldsr0_pc", pc, 20'h00401);
    issue(3'd3, 20'h00100, 3'b0);
    check("jz_nt_pc", pc, 20'h00402);
    check("jz_nt_redirect", redirect, 1'b0);
    issue(3'd4, 20'h00100, 3'b0);
    check("js_nt_pc", pc, 20'h00403);
    check("js_nt_redirect", redirect, 1'b0);
    issue(3'd5, 20'h00100, 3'b0);
    check("jzs_nt_pc", pc, 20'h00404);
    check("jzs_nt_ready", op_ready, 1'b1);

    // LDSR sets sign, JZS then taken.
    issue(3'd6, 20'h0, 3'b010);
    check("ldsr_status", status, 3'b010);
    check("ldsr_pc", pc, 20'h00405);
    issue(3'd5, 20'h00020, 3'b0);
    check("jzs_t_pc", pc, 20'h00020);
    check("jzs_t_redirect", redirect, 1'b1);
    tick();

    // XSR with concurrent flags: XSR result wins.
    flag_valid = 1'b1; alu_sign = 1'b1;
    issue(3'd7, 20'h0, 3'b101);
    flag_valid = 1'b0; alu_sign = 1'b0;
    check("xsr_status", status, 3'b111);
    check("xsr_pc", pc, 20'h00021);

    // Move to 0x10, then trap.
    issue(3'd2, 20'h00010, 3'b0);
    check("jmp_pc", pc, 20'h00010);
    tick();
    issue(3'd0, 20'h0, 3'b0);
    check("trap_epc", epc, 20'h00010);
    check("trap_pc", pc, 20'hFFF00);
    check("trap_active", trap_active, 1'b1);
    check("trap_redirect", redirect, 1'b1);
    check("trap_ready", op_ready, 1'b0);
    op_valid = 1'b1; op_code = 3'd1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("trap_hold%0d_pc", i), pc, 20'hFFF00);
      check($sformatf("trap_hold%0d_ready", i), op_ready, 1'b0);
      check($sformatf("trap_hold%0d_redirect", i), redirect, 1'b0);
    end
    trap_ack = 1'b1;
    tick();
    trap_ack = 1'b0;
    check("ack_ready", op_ready, 1'b1);
    check("ack_trap_active", trap_active, 1'b0);
    check("ack_pc", pc, 20'hFFF00);
    tick();
    op_valid = 1'b0;
    check("post_ack_accept_pc", pc, 20'hFFF01);

    // trap_ack in RUN is ignored.
    trap_ack = 1'b1;
    tick();
    trap_ack = 1'b0;
    check("stray_ack_ready", op_ready, 1'b1);
    check("stray_ack_pc", pc, 20'hFFF01);

    // PC wrap.
    issue(3'd2, 20'hFFFFF, 3'b0);
    check("jmp_max_pc", pc, 20'hFFFFF);
    tick();
    issue(3'd1, 20'h0, 3'b0);
    check("wrap_pc", pc, 20'h00000);
    check("wrap_redirect", redirect, 1'b0);

    // Asynchronous reset in the middle of TRAP.
    issue(3'd0, 20'h0, 3'b0);
    check("trap2_active", trap_active, 1'b1);
    check("trap2_status_kept", status, 3'b111);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("async_reset");
    tick();
    check("reset_hold_redirect", redirect, 1'b0);
    rst_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/flow_unit.md
# flow_unit

Program-flow unit that consumes the zero/sign/carry flags produced by the 20-bit ALU and executes the program-flow operation class: trap, no-op, unconditional jump, jump zero, jump sign, jump zero-sign, load status register, and XOR status register. It holds the program counter, the 3-bit status register and the trap return address. It sits between the instruction issue stage, which hands it flow operations over a valid/ready handshake, and the fetch stage, which it steers via `pc` and `redirect`.

## Interface
- `WIDTH`, 20, address/PC width
- `RESET_PC`, 0, PC value after reset
- `TRAP_VEC`, 20'hFFF00, PC loaded on trap entry
- `clk`  in  1  clock, all state on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `flag_valid`  in  1  ALU flags valid this cycle
- `alu_zero`, `alu_sign`, `alu_carry`  in  1 each  ALU flag outputs
- `op_valid`  in  1  flow operation offered
- `op_ready`  out  1  unit can accept an operation
- `op_code`  in  3  0 TRAP, 1 NOP, 2 JMP, 3 JZ, 4 JS, 5 JZS, 6 LDSR, 7 XSR
- `op_target`  in  WIDTH  jump target address
- `op_imm`  in  3  status operand for LDSR/XSR
- `trap_ack`  in  1  trap handler done, resume
- `pc`  out  WIDTH  current program counter (registered)
- `status`  out  3  {carry, sign, zero}: bit0 zero, bit1 sign, bit2 carry
- `epc`  out  WIDTH  PC of the last trapping operation
- `redirect`  out  1  one-cycle pulse: `pc` changed non-sequentially
- `trap_active`  out  1  high while in TRAP state

## Operation
- States: RUN, FLUSH, TRAP. `op_ready` = (state == RUN), decoded from registered state.
- An operation is accepted when `op_valid & op_ready`. No action occurs without acceptance.
- NOP: `pc <= pc + 1`.
- JMP: always taken.
- JZ: taken if `status[0]`.
- JS: taken if `status[1]`.
- JZS: taken if `status[0] | status[1]` (result ≤ 0).
- Taken jump: `pc <= op_target`, next state FLUSH.
- Not taken jump: `pc <= pc + 1`, stay in RUN.
- Jump conditions use the registered `status` only. Flags arriving in the same cycle are not forwarded.
- LDSR: `status <= op_imm`, `pc <= pc + 1`.
- XSR: `status <= status ^ op_imm`, `pc <= pc + 1`.
- TRAP: `epc <= pc`, `pc <= TRAP_VEC`, next state TRAP.
- FLUSH: lasts exactly one cycle. `redirect` = 1, `op_ready` = 0, then returns to RUN.
- TRAP state:
  - `trap_active` = 1, `op_ready` = 0.
  - `redirect` = 1 only in the first TRAP cycle.
  - `trap_ack` returns the unit to RUN on the next edge; `pc` stays at `TRAP_VEC`. Software jumps to `epc`.
  - `trap_ack` outside the TRAP state is ignored.
- Flag capture: `flag_valid` loads `status <= {alu_carry, alu_sign, alu_zero}` in every state.
- Simultaneous accepted LDSR/XSR and `flag_valid`: the LDSR/XSR result wins and the flags are dropped.
- PC arithmetic is modulo 2^WIDTH: `pc + 1` at 20'hFFFFF wraps to 0, and `redirect` is not asserted on the wrap.
- Reset values: `pc` = `RESET_PC`, `status` = 0, `epc` = 0, state RUN. Therefore `op_ready` = 1, `redirect` = 0, `trap_active` = 0.
- Reset asserted in FLUSH or TRAP aborts immediately to the reset values, and no pending redirect is emitted.

## Timing
- Every operation completes in one cycle: its `pc`/`status`/`epc` update is visible the cycle after acceptance.
- Taken jump or trap: `redirect` is high in the cycle after acceptance, which is the same cycle the new `pc` is visible.
- Taken jump: `op_ready` is low for exactly 1 cycle.
- Trap: `op_ready` is low from the cycle after acceptance until the cycle after `trap_ack` is sampled.
- Back-to-back non-redirecting operations sustain one per cycle.
- A `status` update from cycle N affects a jump accepted in cycle N+1 or later.

## Test plan
- Reset, then 3 NOPs from `RESET_PC` = 0 → `pc` reads 1, 2, 3; `op_ready` stays high; `redirect` stays 0.
- `flag_valid` with zero=1; next cycle JZ to 20'h00400 → `pc` = 20'h00400; `redirect` is high 1 cycle; `op_ready` is low 1 cycle; then RUN.
- `status` = 0, then JZ, JS, JZS each not taken → `pc` increments by 1 each; no redirect. Then LDSR imm=3'b010 followed by JZS → taken.
- XSR imm=3'b101 with `flag_valid` (sign=1) in the same cycle → `status` = old ^ 3'b101; the flags are ignored.
- TRAP at `pc` = 20'h00010 → `epc` = 20'h00010, `pc` = 20'hFFF00, `trap_active` = 1; `op_valid` is held and not accepted for 5 cycles. Then `trap_ack` → RUN, and the op is accepted the next cycle.
- NOP at `pc` = 20'hFFFFF → `pc` = 0 with no redirect. Then `rst_n` is asserted mid-TRAP → all outputs are at reset values asynchronously.
